// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory port arbiter.
package dmem_pkg;

    typedef enum logic {
        ARB_IDLE = 1'b0,
        ARB_WAIT = 1'b1
    } arb_state_t;

    localparam logic [1:0] SIZE_BYTE = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b01;
    localparam logic [1:0] SIZE_WORD = 2'b11;

    localparam int STARVE_LIMIT_DEF = 4;

    // A limit of 0 still needs a one-bit counter so the port widths stay legal.
    function automatic int cnt_width(input int limit);
        return (limit > 0) ? $clog2(limit + 1) : 1;
    endfunction

endpackage

// File: rtl/dmem_arbiter.sv
// Shares the data-memory port between the core load/store path and an external valid/ready requester.
// Latency: grant, mem mux, ready and stall are combinational; external read data returns one edge after grant.
// Backpressure: core wins by default; ext_ready_o stays low until an idle cycle or the starvation bound forces a one-cycle core stall.
module dmem_arbiter
    import dmem_pkg::*;
#(
    parameter int MEM_WIDTH    = 8,
    parameter int STARVE_LIMIT = STARVE_LIMIT_DEF
) (
    input  logic                 clk,
    input  logic                 rst,

    input  logic [MEM_WIDTH-1:0] cpu_addr_i,
    input  logic [31:0]          cpu_wdata_i,
    input  logic                 cpu_read_i,
    input  logic                 cpu_write_i,
    input  logic [1:0]           cpu_size_i,
    output logic [31:0]          cpu_rdata_o,
    output logic                 cpu_stall_o,

    input  logic                 ext_valid_i,
    input  logic                 ext_write_i,
    input  logic [MEM_WIDTH-1:0] ext_addr_i,
    input  logic [31:0]          ext_wdata_i,
    input  logic [1:0]           ext_size_i,
    output logic                 ext_ready_o,
    output logic                 ext_rvalid_o,
    output logic [31:0]          ext_rdata_o,

    output logic [MEM_WIDTH-1:0] mem_addr_o,
    output logic [31:0]          mem_wdata_o,
    output logic [1:0]           mem_size_o,
    output logic                 mem_read_o,
    output logic                 mem_write_o,
    input  logic [31:0]          mem_rdata_i
);

    localparam int             CNT_W   = cnt_width(STARVE_LIMIT);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_LIMIT);

    arb_state_t        state_q, state_d;
    logic [CNT_W-1:0]  starve_cnt_q, starve_cnt_d;
    logic              ext_rvalid_q, ext_rvalid_d;
    logic [31:0]       ext_rdata_q, ext_rdata_d;

    logic core_op;
    logic cnt_sat;
    logic ext_grant;

    always_comb begin
        core_op = cpu_read_i | cpu_write_i;
        // Counter is only non-zero in WAIT, so saturation is only reachable
        // there; a zero limit saturates from IDLE as well.
        cnt_sat = (starve_cnt_q == CNT_MAX) &&
                  ((state_q == ARB_WAIT) || (STARVE_LIMIT == 0));
        ext_grant = ext_valid_i && (!core_op || cnt_sat);

        mem_addr_o  = cpu_addr_i;
        mem_wdata_o = cpu_wdata_i;
        mem_size_o  = cpu_size_i;
        mem_read_o  = cpu_read_i;
        mem_write_o = cpu_write_i;
        ext_ready_o = 1'b0;
        cpu_stall_o = 1'b0;

        state_d      = ARB_IDLE;
        starve_cnt_d = '0;
        ext_rvalid_d = 1'b0;
        ext_rdata_d  = ext_rdata_q;

        if (ext_grant) begin
            mem_addr_o  = ext_addr_i;
            mem_wdata_o = ext_wdata_i;
            mem_size_o  = ext_size_i;
            mem_read_o  = !ext_write_i;
            mem_write_o = ext_write_i;
            ext_ready_o = 1'b1;
            cpu_stall_o = core_op;
            if (!ext_write_i) begin
                ext_rvalid_d = 1'b1;
                ext_rdata_d  = mem_rdata_i;
            end
        end else if (ext_valid_i) begin
            state_d      = ARB_WAIT;
            starve_cnt_d = (starve_cnt_q == CNT_MAX) ? starve_cnt_q
                                                     : starve_cnt_q + CNT_W'(1);
        end

        // Memory strobes and handshakes are inert while reset is held.
        if (!rst) begin
            mem_read_o  = 1'b0;
            mem_write_o = 1'b0;
            ext_ready_o = 1'b0;
            cpu_stall_o = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q      <= ARB_IDLE;
            starve_cnt_q <= '0;
            ext_rvalid_q <= 1'b0;
            ext_rdata_q  <= '0;
        end else begin
            state_q      <= state_d;
            starve_cnt_q <= starve_cnt_d;
            ext_rvalid_q <= ext_rvalid_d;
            ext_rdata_q  <= ext_rdata_d;
        end
    end

    assign cpu_rdata_o  = mem_rdata_i;
    assign ext_rvalid_o = ext_rvalid_q;
    assign ext_rdata_o  = ext_rdata_q;

endmodule
